// File: rtl/pwm_regs_pkg.sv
// Shared register map, ctrl bit positions, fade state encoding and the fade step helper.
// Used by pwm_fade_controller and its testbench.
package pwm_regs_pkg;

   localparam logic [6:0] ADDR_EN_OUT_LO     = 7'd0;
   localparam logic [6:0] ADDR_EN_OUT_HI     = 7'd1;
   localparam logic [6:0] ADDR_EN_PWM_LO     = 7'd2;
   localparam logic [6:0] ADDR_EN_PWM_HI     = 7'd3;
   localparam logic [6:0] ADDR_PWM_DUTY      = 7'd4;
   localparam logic [6:0] ADDR_FADE_TARGET   = 7'd5;
   localparam logic [6:0] ADDR_FADE_STEP     = 7'd6;
   localparam logic [6:0] ADDR_FADE_PRESCALE = 7'd7;
   localparam logic [6:0] ADDR_FADE_CTRL     = 7'd8;

   localparam int CTRL_START = 0;
   localparam int CTRL_LOOP  = 1;

   typedef enum logic {FADE_IDLE, FADE_RUN} fade_state_t;

   // Returns {reached, next_duty}; 9-bit distance compare guarantees no overshoot or wrap.
   function automatic logic [8:0] fade_next(input logic [7:0] duty,
                                            input logic [7:0] target,
                                            input logic [7:0] step);
      logic [8:0] step_eff;
      logic [8:0] diff;
      step_eff = (step == 8'd0) ? 9'd1 : {1'b0, step};
      diff     = (target >= duty) ? ({1'b0, target} - {1'b0, duty})
                                  : ({1'b0, duty} - {1'b0, target});
      if (diff <= step_eff)
         return {1'b1, target};
      else if (target > duty)
         return {1'b0, duty + step_eff[7:0]};
      else
         return {1'b0, duty - step_eff[7:0]};
   endfunction

endpackage

// File: rtl/pwm_fade_controller_if.sv
// Register write strobe and combinational readback port between SPI side and the controller.
interface pwm_fade_controller_if;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   logic [6:0] rd_addr;
   logic [7:0] rd_data;

   modport master (output wr_valid, wr_addr, wr_data, rd_addr, input rd_data);
   modport slave  (input wr_valid, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/fade_tick_gen.sv
// Fade prescaler: single-cycle tick every (prescale+1) << PRESCALE_SHIFT cycles while enabled.
// Counter is held at zero when disabled or cleared; tick is combinational from the count.
module fade_tick_gen #(
   parameter int PRESCALE_SHIFT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   input  logic [7:0] prescale,
   output logic       tick
);
   localparam int CW = 9 + PRESCALE_SHIFT;

   logic [CW-1:0] cnt;
   logic [CW-1:0] term;

   assign term = ((CW'(prescale) + CW'(1)) << PRESCALE_SHIFT) - CW'(1);
   assign tick = en && (cnt == term);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr || !en || tick)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/pwm_fade_controller.sv
// PWM config register file with a duty-cycle fade engine; SPI writes always beat fade updates.
// Writes land one cycle after the strobe. Ping-pong looping is built only with PWM_FADE_LOOP_EN.
module pwm_fade_controller
   import pwm_regs_pkg::*;
#(
   parameter int PRESCALE_SHIFT = 8,
   parameter int NUM_ADDR       = 9
) (
   input  logic                    clk,
   input  logic                    rst_n,
   pwm_fade_controller_if.slave    bus,
   output logic [7:0]              en_reg_out_7_0,
   output logic [7:0]              en_reg_out_15_8,
   output logic [7:0]              en_reg_pwm_7_0,
   output logic [7:0]              en_reg_pwm_15_8,
   output logic [7:0]              pwm_duty_cycle,
   output logic                    fade_busy,
   output logic                    fade_done
);
   fade_state_t state;
   logic [7:0]  fade_target;
   logic [7:0]  fade_step;
   logic [7:0]  fade_prescale;
   logic        ctrl_start;
   logic        ctrl_loop;
`ifdef PWM_FADE_LOOP_EN
   logic [7:0]  start_duty;
`else
   assign ctrl_loop = 1'b0;
`endif

   logic       wr_hit;
   logic       wr_duty;
   logic       wr_ctrl;
   logic       tick_raw;
   logic       tick;
   logic [8:0] nxt;

   assign wr_hit    = bus.wr_valid && (bus.wr_addr < 7'(NUM_ADDR));
   assign wr_duty   = wr_hit && (bus.wr_addr == ADDR_PWM_DUTY);
   assign wr_ctrl   = wr_hit && (bus.wr_addr == ADDR_FADE_CTRL);
   // Writes to duty or ctrl pre-empt a coincident tick entirely, including its done pulse.
   assign tick      = tick_raw && !wr_duty && !wr_ctrl;
   assign nxt       = fade_next(pwm_duty_cycle, fade_target, fade_step);
   assign fade_busy = (state == FADE_RUN);

   fade_tick_gen #(.PRESCALE_SHIFT(PRESCALE_SHIFT)) u_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (state == FADE_RUN),
      .clr      (wr_ctrl && bus.wr_data[CTRL_START]),
      .prescale (fade_prescale),
      .tick     (tick_raw)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= FADE_IDLE;
         en_reg_out_7_0  <= 8'd0;
         en_reg_out_15_8 <= 8'd0;
         en_reg_pwm_7_0  <= 8'd0;
         en_reg_pwm_15_8 <= 8'd0;
         pwm_duty_cycle  <= 8'd0;
         fade_target     <= 8'd0;
         fade_step       <= 8'd0;
         fade_prescale   <= 8'd0;
         ctrl_start      <= 1'b0;
         fade_done       <= 1'b0;
`ifdef PWM_FADE_LOOP_EN
         ctrl_loop       <= 1'b0;
         start_duty      <= 8'd0;
`endif
      end else begin
         fade_done <= 1'b0;
         if (tick) begin
            pwm_duty_cycle <= nxt[7:0];
            if (nxt[8]) begin
               fade_done <= 1'b1;
`ifdef PWM_FADE_LOOP_EN
               if (ctrl_loop) begin
                  fade_target <= start_duty;
                  start_duty  <= fade_target;
               end else begin
                  state      <= FADE_IDLE;
                  ctrl_start <= 1'b0;
               end
`else
               state      <= FADE_IDLE;
               ctrl_start <= 1'b0;
`endif
            end
         end
         // SPI write block comes last so it overrides any fade update in the same cycle.
         if (wr_hit) begin
            case (bus.wr_addr)
               ADDR_EN_OUT_LO:     en_reg_out_7_0  <= bus.wr_data;
               ADDR_EN_OUT_HI:     en_reg_out_15_8 <= bus.wr_data;
               ADDR_EN_PWM_LO:     en_reg_pwm_7_0  <= bus.wr_data;
               ADDR_EN_PWM_HI:     en_reg_pwm_15_8 <= bus.wr_data;
               ADDR_PWM_DUTY: begin
                  pwm_duty_cycle <= bus.wr_data;
                  state          <= FADE_IDLE;
                  ctrl_start     <= 1'b0;
               end
               ADDR_FADE_TARGET:   fade_target   <= bus.wr_data;
               ADDR_FADE_STEP:     fade_step     <= bus.wr_data;
               ADDR_FADE_PRESCALE: fade_prescale <= bus.wr_data;
               ADDR_FADE_CTRL: begin
                  ctrl_start <= bus.wr_data[CTRL_START];
`ifdef PWM_FADE_LOOP_EN
                  ctrl_loop  <= bus.wr_data[CTRL_LOOP];
                  start_duty <= pwm_duty_cycle;
`endif
                  state <= bus.wr_data[CTRL_START] ? FADE_RUN : FADE_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      bus.rd_data = 8'd0;
      case (bus.rd_addr)
         ADDR_EN_OUT_LO:     bus.rd_data = en_reg_out_7_0;
         ADDR_EN_OUT_HI:     bus.rd_data = en_reg_out_15_8;
         ADDR_EN_PWM_LO:     bus.rd_data = en_reg_pwm_7_0;
         ADDR_EN_PWM_HI:     bus.rd_data = en_reg_pwm_15_8;
         ADDR_PWM_DUTY:      bus.rd_data = pwm_duty_cycle;
         ADDR_FADE_TARGET:   bus.rd_data = fade_target;
         ADDR_FADE_STEP:     bus.rd_data = fade_step;
         ADDR_FADE_PRESCALE: bus.rd_data = fade_prescale;
         ADDR_FADE_CTRL:     bus.rd_data = {6'd0, ctrl_loop, ctrl_start};
         default:            bus.rd_data = 8'd0;
      endcase
   end
endmodule

// File: tb/tb_pwm_fade_controller.sv
// Self-checking bench for pwm_fade_controller with PRESCALE_SHIFT = 0 (tick every prescale+1 cycles).
module tb_pwm_fade_controller;
   import pwm_regs_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
   logic       busy, done;

   always #5 clk = ~clk;

   pwm_fade_controller_if bus();

   pwm_fade_controller #(.PRESCALE_SHIFT(0), .NUM_ADDR(9)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus),
      .en_reg_out_7_0  (out_lo),
      .en_reg_out_15_8 (out_hi),
      .en_reg_pwm_7_0  (pwm_lo),
      .en_reg_pwm_15_8 (pwm_hi),
      .pwm_duty_cycle  (duty),
      .fade_busy       (busy),
      .fade_done       (done)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] duty;
      logic       busy;
      logic       done;
   } trace_t;
   trace_t exp_q[$];

   typedef struct {
      logic [6:0] addr;
      logic [7:0] data;
      logic [7:0] exp_rd;
   } vec_t;
   vec_t vecs[12];

`ifdef PWM_FADE_LOOP_EN
   localparam logic LOOP_ON = 1'b1;
`else
   localparam logic LOOP_ON = 1'b0;
`endif

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic wr(input logic [6:0] a, input logic [7:0] d);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      @(posedge clk);
      #1 bus.wr_valid = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [6:0] a, input logic [7:0] exp_v);
      bus.rd_addr = a;
      #1 chk(name, int'(bus.rd_data), int'(exp_v));
   endtask

   task automatic push(input int d, input bit b, input bit dn);
      trace_t t;
      t.duty = 8'(d);
      t.busy = b;
      t.done = dn;
      exp_q.push_back(t);
   endtask

   // Samples every negedge after the start write; optional SPI write driven at negedge inj_k.
   task automatic run_trace(input string name, input int n, input int inj_k,
                            input logic [6:0] ia, input logic [7:0] id);
      trace_t e;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            chk($sformatf("%s_k%0d_queue_empty", name, k), 0, 1);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s_k%0d_duty", name, k), int'(duty), int'(e.duty));
            chk($sformatf("%s_k%0d_busy", name, k), int'(busy), int'(e.busy));
            chk($sformatf("%s_k%0d_done", name, k), int'(done), int'(e.done));
         end
         if (k == inj_k) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = ia;
            bus.wr_data  = id;
         end else if (k == inj_k + 1) begin
            bus.wr_valid = 1'b0;
         end
      end
      bus.wr_valid = 1'b0;
      exp_q.delete();
   endtask

   task automatic setup_fade(input int d, input int t, input int s);
      wr(ADDR_PWM_DUTY, 8'(d));
      wr(ADDR_FADE_TARGET, 8'(t));
      wr(ADDR_FADE_STEP, 8'(s));
      wr(ADDR_FADE_PRESCALE, 8'd1);
   endtask

   initial begin
      vecs[0]  = '{ADDR_EN_OUT_LO,     8'hA5, 8'hA5};
      vecs[1]  = '{ADDR_EN_OUT_HI,     8'h5A, 8'h5A};
      vecs[2]  = '{ADDR_EN_PWM_LO,     8'h3C, 8'h3C};
      vecs[3]  = '{ADDR_EN_PWM_HI,     8'hC3, 8'hC3};
      vecs[4]  = '{ADDR_PWM_DUTY,      8'h11, 8'h11};
      vecs[5]  = '{ADDR_FADE_TARGET,   8'h22, 8'h22};
      vecs[6]  = '{ADDR_FADE_STEP,     8'h33, 8'h33};
      vecs[7]  = '{ADDR_FADE_PRESCALE, 8'h44, 8'h44};
      vecs[8]  = '{ADDR_FADE_CTRL,     8'hFC, 8'h00};
      vecs[9]  = '{ADDR_FADE_CTRL,     8'h02, {6'd0, LOOP_ON, 1'b0}};
      vecs[10] = '{7'd9,               8'h77, 8'h00};
      vecs[11] = '{7'd127,             8'hFF, 8'h00};

      bus.wr_valid = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.rd_addr  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      for (int a = 0; a < 9; a++) rd_chk($sformatf("reset_rd_%0d", a), 7'(a), 8'd0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_duty", int'(duty), 0);
      chk("reset_out_lo", int'(out_lo), 0);

      // Register write/readback table
      for (int i = 0; i < 12; i++) begin
         wr(vecs[i].addr, vecs[i].data);
         rd_chk($sformatf("tbl_%0d_addr%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].exp_rd);
      end
      chk("tbl_out_lo", int'(out_lo), 'hA5);
      chk("tbl_out_hi", int'(out_hi), 'h5A);
      chk("tbl_pwm_lo", int'(pwm_lo), 'h3C);
      chk("tbl_pwm_hi", int'(pwm_hi), 'hC3);
      chk("tbl_duty", int'(duty), 'h11);
      rd_chk("tbl_after_bad_addr_target", ADDR_FADE_TARGET, 8'h22);
      chk("tbl_busy_idle", int'(busy), 0);

      // Up fade 10 -> 40 step 10, tick every 2 cycles
      setup_fade(10, 40, 10);
      for (int k = 0; k < 8; k++) push(10 + 10 * (k / 2), k < 6, k == 6);
      wr(ADDR_FADE_CTRL, 8'h01);
      run_trace("up", 8, -1, '0, '0);
      rd_chk("up_ctrl_cleared", ADDR_FADE_CTRL, 8'h00);

      // Down fade 200 -> 195 with step 0 (effective 1)
      setup_fade(200, 195, 0);
      for (int k = 0; k < 12; k++) push(200 - (k < 10 ? k / 2 : 5), k < 10, k == 10);
      wr(ADDR_FADE_CTRL, 8'h01);
      run_trace("down", 12, -1, '0, '0);

      // Near top: 250 -> 255 step 10 clamps on first tick
      setup_fade(250, 255, 10);
      push(250, 1, 0); push(250, 1, 0); push(255, 0, 1); push(255, 0, 0);
      wr(ADDR_FADE_CTRL, 8'h01);
      run_trace("top", 4, -1, '0, '0);

      // Target equals duty at start
      setup_fade(77, 77, 5);
      push(77, 1, 0); push(77, 1, 0); push(77, 0, 1); push(77, 0, 0);
      wr(ADDR_FADE_CTRL, 8'h01);
      run_trace("equal", 4, -1, '0, '0);

      // SPI duty write coincident with the third tick aborts the fade
      setup_fade(0, 100, 10);
      for (int k = 0; k < 6; k++) push(10 * (k / 2), 1, 0);
      push('h55, 0, 0); push('h55, 0, 0);
      wr(ADDR_FADE_CTRL, 8'h01);
      run_trace("abort", 8, 5, ADDR_PWM_DUTY, 8'h55);
      rd_chk("abort_duty_rd", ADDR_PWM_DUTY, 8'h55);
      rd_chk("abort_ctrl_rd", ADDR_FADE_CTRL, 8'h00);

      // Loop request: ping-pong when built with the loop feature, one-shot otherwise
      setup_fade(0, 4, 2);
`ifdef PWM_FADE_LOOP_EN
      push(0, 1, 0); push(0, 1, 0); push(2, 1, 0); push(2, 1, 0);
      push(4, 1, 1); push(4, 1, 0); push(2, 1, 0); push(2, 1, 0);
      push(0, 1, 1); push(0, 1, 0); push(2, 1, 0); push(2, 0, 0); push(2, 0, 0);
`else
      push(0, 1, 0); push(0, 1, 0); push(2, 1, 0); push(2, 1, 0); push(4, 0, 1);
      for (int k = 5; k < 13; k++) push(4, 0, 0);
`endif
      wr(ADDR_FADE_CTRL, 8'h03);
      run_trace("loop", 13, 10, ADDR_FADE_CTRL, 8'h00);
      wr(ADDR_FADE_CTRL, 8'h02);
      rd_chk("loop_ctrl_bit1", ADDR_FADE_CTRL, {6'd0, LOOP_ON, 1'b0});

      // Asynchronous reset mid-fade
      setup_fade(0, 200, 1);
      wr(ADDR_FADE_CTRL, 8'h01);
      repeat (3) @(negedge clk);
      chk("midrst_pre_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_duty", int'(duty), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_out_lo", int'(out_lo), 0);
      rd_chk("midrst_target", ADDR_FADE_TARGET, 8'd0);
      rd_chk("midrst_ctrl", ADDR_FADE_CTRL, 8'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("postrst_duty", int'(duty), 0);
      chk("postrst_busy", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
